// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the PL-side master and the register-file slave.
// Holds the response codes, the master FSM states and the fixed data width.
package axi_lite_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD,
    RD_DATA,
    RSP
  } state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle with initiator (master) and target (slave) views.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns a command/response handshake into
// bus reads and writes, with a sticky watchdog flag for slaves that never answer.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = DATA_WIDTH,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            axi_aclk,
  input  logic                            axi_areset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            timeout,
  axi_lite_if.master                      m_axi
);

  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t state, state_next;

  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic                            write_q;
  resp_t                           resp_q;
  logic                            aw_done, w_done;
  logic [15:0]                     wdog_count;
  logic                            timeout_q;

  logic cmd_accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs, bus_state;

  // Every VALID/READY is decoded from registered state only, so reset drops them at once.
  assign cmd_ready     = (state == IDLE) && !axi_areset;
  assign m_axi.awvalid = (state == WR) && !aw_done;
  assign m_axi.wvalid  = (state == WR) && !w_done;
  assign m_axi.bready  = (state == WR) || (state == WR_RESP);
  assign m_axi.arvalid = (state == RD);
  assign m_axi.rready  = (state == RD_DATA);
  assign rsp_valid     = (state == RSP);

  assign m_axi.awaddr = addr_q;
  assign m_axi.araddr = addr_q;
  assign m_axi.wdata  = wdata_q;
  assign m_axi.wstrb  = wstrb_q;
  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;

  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign timeout   = timeout_q;

  assign cmd_accept = cmd_valid && cmd_ready;
  assign aw_hs      = m_axi.awvalid && m_axi.awready;
  assign w_hs       = m_axi.wvalid && m_axi.wready;
  assign b_hs       = m_axi.bvalid && m_axi.bready;
  assign ar_hs      = m_axi.arvalid && m_axi.arready;
  assign r_hs       = m_axi.rvalid && m_axi.rready;
  assign rsp_hs     = rsp_valid && rsp_ready;
  assign bus_state  = state inside {WR, WR_RESP, RD, RD_DATA};

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_accept) begin
          state_next = cmd_write ? WR : RD;
        end
      end
      WR: begin
        // A B beat arriving in the cycle that completes AW/W is consumed right away.
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_next = b_hs ? RSP : WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_next = RSP;
        end
      end
      RD: begin
        if (ar_hs) begin
          state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_hs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      resp_q  <= OKAY;
    end else begin
      if (cmd_accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        write_q <= cmd_write;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (state_next == RSP && state != RSP) begin
        if (write_q) begin
          resp_q  <= resp_t'(m_axi.bresp);
          rdata_q <= '0;
        end else begin
          resp_q  <= resp_t'(m_axi.rresp);
          rdata_q <= m_axi.rdata;
        end
      end
    end
  end

  // Watchdog only observes; the bus transaction is left running after the flag sets.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wdog_count <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_next != state) begin
        wdog_count <= '0;
      end else if (bus_state && wdog_count != WDOG_LIMIT) begin
        wdog_count <= wdog_count + 16'd1;
      end
      if (cmd_accept) begin
        timeout_q <= 1'b0;
      end else if (bus_state && state_next == state && wdog_count != WDOG_LIMIT &&
                   (wdog_count + 16'd1) == WDOG_LIMIT) begin
        timeout_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a delay-configurable AXI4-Lite slave plus a word-array
// reference model of the register file that predicts every response.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          timeout;

  axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout(timeout),
    .m_axi(bus)
  );

  int checks = 0;
  int failures = 0;

  // Slave configuration and bookkeeping
  int cfg_aw_delay = 0, cfg_w_delay = 0, cfg_b_delay = 0, cfg_ar_delay = 0, cfg_r_delay = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit got_aw, got_w, got_ar, b_fire, r_fire;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  int aw_hs_count = 0, w_hs_count = 0;
  logic [31:0] slave_mem [16];
  logic [31:0] exp_mem [16];

  // Slave acts at the falling edge: its READY/VALID then hold until the next rising edge.
  initial begin
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
        got_aw = 0; got_w = 0; got_ar = 0; b_fire = 0; r_fire = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (b_fire) begin
          bus.bvalid = 0; b_fire = 0; got_aw = 0; got_w = 0; b_cnt = 0;
        end else if (!bus.bvalid && got_aw && got_w) begin
          if (b_cnt >= cfg_b_delay) begin
            bus.bvalid = 1;
            if (s_awaddr == 32'h40) begin
              bus.bresp = 2'b10;
            end else begin
              bus.bresp = 2'b00;
              for (int i = 0; i < 4; i++)
                if (s_wstrb[i]) slave_mem[s_awaddr[5:2]][8*i +: 8] = s_wdata[8*i +: 8];
            end
          end else b_cnt++;
        end
        if (bus.bvalid && bus.bready) b_fire = 1;

        if (bus.awvalid && !got_aw) begin bus.awready = (aw_cnt >= cfg_aw_delay); aw_cnt++; end
        else begin bus.awready = 0; aw_cnt = 0; end
        if (bus.awvalid && bus.awready) begin got_aw = 1; s_awaddr = bus.awaddr; aw_hs_count++; end

        if (bus.wvalid && !got_w) begin bus.wready = (w_cnt >= cfg_w_delay); w_cnt++; end
        else begin bus.wready = 0; w_cnt = 0; end
        if (bus.wvalid && bus.wready) begin
          got_w = 1; s_wdata = bus.wdata; s_wstrb = bus.wstrb; w_hs_count++;
        end

        if (r_fire) begin
          bus.rvalid = 0; r_fire = 0; got_ar = 0; r_cnt = 0;
        end else if (!bus.rvalid && got_ar) begin
          if (r_cnt >= cfg_r_delay) begin
            bus.rvalid = 1;
            if (s_araddr == 32'h40) begin bus.rresp = 2'b10; bus.rdata = 0; end
            else begin bus.rresp = 2'b00; bus.rdata = slave_mem[s_araddr[5:2]]; end
          end else r_cnt++;
        end
        if (bus.rvalid && bus.rready) r_fire = 1;

        if (bus.arvalid && !got_ar) begin bus.arready = (ar_cnt >= cfg_ar_delay); ar_cnt++; end
        else begin bus.arready = 0; ar_cnt = 0; end
        if (bus.arvalid && bus.arready) begin got_ar = 1; s_araddr = bus.araddr; end
      end
    end
  end

  // Reference model: 16 words, byte strobes merge, address 0x40 is an error target.
  function automatic logic [1:0] model_resp(input logic [31:0] addr);
    return (addr == 32'h40) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    return (addr == 32'h40) ? 32'h0 : exp_mem[addr[5:2]];
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    if (addr != 32'h40)
      for (int i = 0; i < 4; i++)
        if (strb[i]) exp_mem[addr[5:2]][8*i +: 8] = data[8*i +: 8];
  endfunction

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int hold, output int lat,
                         output logic [31:0] rdata, output logic [1:0] resp,
                         output logic rwrite, output bit busy_ready, output bit ok);
    int cnt;
    ok = 1; busy_ready = 0; lat = 0; rdata = 0; resp = 0; rwrite = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    cnt = 0;
    while (!cmd_ready && cnt < 100) begin @(negedge clk); cnt++; end
    if (!cmd_ready) begin ok = 0; cmd_valid = 0; return; end
    @(negedge clk);
    cmd_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      if (cmd_ready) busy_ready = 1;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin ok = 0; return; end
    for (int i = 0; i < hold; i++) begin
      if (cmd_ready) busy_ready = 1;
      @(negedge clk);
    end
    if (cmd_ready) busy_ready = 1;
    rsp_ready = 1; rdata = rsp_rdata; resp = rsp_resp; rwrite = rsp_write;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, rsp_valid, timeout} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %b want 0000000",
               {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, rsp_valid, timeout});
    end
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++;
    if ({bus.awprot, bus.arprot, rsp_rdata, rsp_resp} !== '0) begin
      failures++; $display("[TB] FAIL post_reset_zero: prot/rdata/resp not all zero");
    end
  endtask

  task automatic test_read_sequence();
    int lat; logic [31:0] rd; logic [1:0] resp; logic rw; bit busy, ok;
    logic [31:0] addrs [2] = '{32'h00, 32'h04};
    logic [31:0] want  [2] = '{32'hDEADBEEF, 32'h76543210};
    for (int k = 0; k < 2; k++) begin
      run_cmd(0, addrs[k], 32'h0, 4'h0, 0, lat, rd, resp, rw, busy, ok);
      checks++;
      if (!ok || rd !== want[k]) begin failures++; $display("[TB] FAIL read_seq_data: got %h want %h ok=%0d", rd, want[k], ok); end
      checks++;
      if (resp !== OKAY || rw !== 1'b0) begin failures++; $display("[TB] FAIL read_seq_resp: got resp=%b write=%b want 00/0", resp, rw); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL read_seq_cmd_ready: cmd_ready high while busy"); end
    end
  endtask

  task automatic test_write_aw_first();
    int lat, a0, w0; logic [31:0] rd; logic [1:0] resp; logic rw; bit busy, ok;
    a0 = aw_hs_count; w0 = w_hs_count;
    cfg_aw_delay = 0; cfg_w_delay = 2;
    run_cmd(1, 32'h08, 32'hA5A50001, 4'hF, 0, lat, rd, resp, rw, busy, ok);
    model_write(32'h08, 32'hA5A50001, 4'hF);
    cfg_w_delay = 0;
    checks++;
    if (!ok || (aw_hs_count - a0) != 1 || (w_hs_count - w0) != 1) begin
      failures++; $display("[TB] FAIL write_hs_count: aw=%0d w=%0d want 1/1 ok=%0d", aw_hs_count - a0, w_hs_count - w0, ok);
    end
    checks++;
    if (resp !== OKAY || rw !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("[TB] FAIL write_rsp: got resp=%b write=%b rdata=%h want 00/1/0", resp, rw, rd);
    end
    run_cmd(0, 32'h08, 32'h0, 4'h0, 0, lat, rd, resp, rw, busy, ok);
    checks++;
    if (!ok || rd !== 32'hA5A50001) begin failures++; $display("[TB] FAIL write_readback: got %h want a5a50001", rd); end
  endtask

  task automatic test_min_latency();
    int lat; logic [31:0] rd; logic [1:0] resp; logic rw; bit busy, ok;
    run_cmd(1, 32'h0C, 32'h1234ABCD, 4'hF, 0, lat, rd, resp, rw, busy, ok);
    model_write(32'h0C, 32'h1234ABCD, 4'hF);
    checks++;
    if (!ok || lat != 3) begin failures++; $display("[TB] FAIL write_latency: got %0d want 3", lat); end
    run_cmd(0, 32'h0C, 32'h0, 4'h0, 0, lat, rd, resp, rw, busy, ok);
    checks++;
    if (!ok || lat != 3 || rd !== model_read(32'h0C)) begin
      failures++; $display("[TB] FAIL read_latency: got lat=%0d data=%h want 3/%h", lat, rd, model_read(32'h0C));
    end
  endtask

  task automatic test_backpressure();
    int cnt; logic [31:0] want;
    want = model_read(32'h04);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h04; cmd_wdata = 0; cmd_wstrb = 0;
    cnt = 0;
    while (!rsp_valid && cnt < 50) begin @(negedge clk); cnt++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== want || cmd_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_stable: cycle %0d got valid=%b data=%h cmd_ready=%b want 1/%h/0", i, rsp_valid, rsp_rdata, cmd_ready, want);
      end
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL bp_reaccept: got cmd_ready=%b rsp_valid=%b want 1/0", cmd_ready, rsp_valid);
    end
    @(negedge clk);
    cmd_valid = 0;
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_second_accept: got cmd_ready=%b want 0", cmd_ready); end
    cnt = 0;
    while (!rsp_valid && cnt < 50) begin @(negedge clk); cnt++; end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== want) begin
      failures++; $display("[TB] FAIL bp_second_rsp: got valid=%b data=%h want 1/%h", rsp_valid, rsp_rdata, want);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_timeout();
    int cnt, lat; logic [31:0] want, rd; logic [1:0] resp; logic rw; bit busy, ok;
    want = model_read(32'h0C);
    cfg_ar_delay = 25;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h0C; cmd_wdata = 0; cmd_wstrb = 0;
    cnt = 0;
    while (!cmd_ready && cnt < 50) begin @(negedge clk); cnt++; end
    @(negedge clk);
    cmd_valid = 0;
    repeat (11) @(negedge clk);
    checks++;
    if (timeout !== 1'b0 || bus.arvalid !== 1'b1) begin
      failures++; $display("[TB] FAIL timeout_early: got timeout=%b arvalid=%b want 0/1", timeout, bus.arvalid);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (timeout !== 1'b1 || bus.arvalid !== 1'b1) begin
      failures++; $display("[TB] FAIL timeout_set: got timeout=%b arvalid=%b want 1/1", timeout, bus.arvalid);
    end
    cnt = 0;
    while (!rsp_valid && cnt < 100) begin @(negedge clk); cnt++; end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== want || rsp_resp !== OKAY) begin
      failures++; $display("[TB] FAIL timeout_read_done: got valid=%b data=%h resp=%b want 1/%h/00", rsp_valid, rsp_rdata, rsp_resp, want);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    checks++;
    if (timeout !== 1'b1) begin failures++; $display("[TB] FAIL timeout_sticky: got %b want 1", timeout); end
    cfg_ar_delay = 0;
    run_cmd(0, 32'h00, 32'h0, 4'h0, 0, lat, rd, resp, rw, busy, ok);
    checks++;
    if (!ok || timeout !== 1'b0 || rd !== model_read(32'h00)) begin
      failures++; $display("[TB] FAIL timeout_clear: got timeout=%b data=%h want 0/%h", timeout, rd, model_read(32'h00));
    end
  endtask

  task automatic test_slverr();
    int lat; logic [31:0] rd; logic [1:0] resp; logic rw; bit busy, ok;
    run_cmd(1, 32'h40, 32'hCAFEF00D, 4'hF, 0, lat, rd, resp, rw, busy, ok);
    model_write(32'h40, 32'hCAFEF00D, 4'hF);
    checks++;
    if (!ok || resp !== 2'b10 || timeout !== 1'b0 || rw !== 1'b1) begin
      failures++; $display("[TB] FAIL slverr_write: got resp=%b timeout=%b write=%b want 10/0/1", resp, timeout, rw);
    end
    run_cmd(0, 32'h40, 32'h0, 4'h0, 0, lat, rd, resp, rw, busy, ok);
    checks++;
    if (!ok || resp !== 2'b10 || rd !== 32'h0) begin
      failures++; $display("[TB] FAIL slverr_read: got resp=%b data=%h want 10/0", resp, rd);
    end
    run_cmd(0, 32'h00, 32'h0, 4'h0, 0, lat, rd, resp, rw, busy, ok);
    checks++;
    if (!ok || rd !== model_read(32'h00)) begin
      failures++; $display("[TB] FAIL slverr_no_alias: got %h want %h", rd, model_read(32'h00));
    end
  endtask

  task automatic test_random();
    int lat, hold; logic [31:0] rd, addr, data, want_data; logic [1:0] resp, want_resp;
    logic [3:0] strb; logic rw; bit busy, ok, wr;
    for (int n = 0; n < 24; n++) begin
      cfg_aw_delay = $urandom_range(0, 3); cfg_w_delay = $urandom_range(0, 3);
      cfg_b_delay = $urandom_range(0, 3); cfg_ar_delay = $urandom_range(0, 3);
      cfg_r_delay = $urandom_range(0, 3);
      wr = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 7) == 0) ? 32'h40 : (32'($urandom_range(0, 15)) << 2);
      data = $urandom;
      strb = 4'($urandom_range(1, 15));
      hold = $urandom_range(0, 2);
      want_resp = model_resp(addr);
      if (wr) begin want_data = 32'h0; model_write(addr, data, strb); end
      else want_data = model_read(addr);
      run_cmd(wr, addr, data, strb, hold, lat, rd, resp, rw, busy, ok);
      checks++;
      if (!ok || rd !== want_data || resp !== want_resp || rw !== wr || busy || timeout !== 1'b0) begin
        failures++;
        $display("[TB] FAIL random_%0d: wr=%0d addr=%h got data=%h resp=%b write=%b busy=%0d to=%b want %h/%b/%0d/0/0",
                 n, wr, addr, rd, resp, rw, busy, timeout, want_data, want_resp, wr);
      end
    end
    cfg_aw_delay = 0; cfg_w_delay = 0; cfg_b_delay = 0; cfg_ar_delay = 0; cfg_r_delay = 0;
  endtask

  task automatic test_reset_midflight();
    int cnt, lat; logic [31:0] rd; logic [1:0] resp; logic rw; bit busy, ok;
    cfg_aw_delay = 10; cfg_w_delay = 10;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
    cnt = 0;
    while (!cmd_ready && cnt < 50) begin @(negedge clk); cnt++; end
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    checks++;
    if (bus.awvalid !== 1'b1) begin failures++; $display("[TB] FAIL midflight_awvalid: got %b want 1", bus.awvalid); end
    #1 rst = 1;
    #1;
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, rsp_valid, cmd_ready} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL midflight_drop: got aw/w/b/rsp/cmd_ready=%b want 00000",
               {bus.awvalid, bus.wvalid, bus.bready, rsp_valid, cmd_ready});
    end
    repeat (2) @(negedge clk);
    #1 rst = 0;
    cfg_aw_delay = 0; cfg_w_delay = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || bus.awvalid !== 1'b0) begin
      failures++; $display("[TB] FAIL midflight_idle: got cmd_ready=%b awvalid=%b want 1/0", cmd_ready, bus.awvalid);
    end
    run_cmd(0, 32'h10, 32'h0, 4'h0, 0, lat, rd, resp, rw, busy, ok);
    checks++;
    if (!ok || rd !== model_read(32'h10)) begin
      failures++; $display("[TB] FAIL midflight_abandoned: got %h want %h", rd, model_read(32'h10));
    end
  endtask

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = 32'h11111111 * i;
      exp_mem[i]   = 32'h11111111 * i;
    end
    slave_mem[0] = 32'hDEADBEEF; exp_mem[0] = 32'hDEADBEEF;
    slave_mem[1] = 32'h76543210; exp_mem[1] = 32'h76543210;
    test_reset();
    test_read_sequence();
    test_write_aw_first();
    test_min_latency();
    test_backpressure();
    test_timeout();
    test_slverr();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL global_timeout: simulation did not complete, got hang want finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator.
- Converts a simple command/response handshake from PL logic into AXI4-Lite read and write transactions.
- Pairs with the register-file slave. A PL-side controller or test sequencer can drive the 16-register file, or any AXI4-Lite slave, over the same bus the PS uses.
- Adds a watchdog that flags slaves that never respond.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 32, data width (32 only).
- TIMEOUT_CYCLES, 1024, cycles waiting in any bus state before the timeout flag sets.

Ports:
- axi_aclk  in  1  clock.
- axi_areset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echoes cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
- rsp_resp  out  2  BRESP/RRESP.
- timeout  out  1  sticky watchdog flag.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master directions and widths.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; the cmd_ready combinational term also reads 0 while reset is asserted.
  - Assertion mid-transaction drops all VALID/READY outputs immediately (asynchronous); the transaction is abandoned.
- States: IDLE, WR, WR_RESP, RD, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On accept in cycle N, register addr/wdata/wstrb/cmd_write.
  - Go to WR if cmd_write, else RD.
- WR:
  - AWVALID and WVALID both high from cycle N+1.
  - Each deasserts on its own handshake (AWVALID&AWREADY, WVALID&WREADY), in either order or the same cycle.
  - When both are done, go to WR_RESP.
  - BREADY=1 throughout WR and WR_RESP. A BVALID observed in WR after both handshakes are done is accepted the same cycle.
- WR_RESP: on BVALID&BREADY, capture BRESP, set rsp_rdata=0, go to RSP.
- RD: ARVALID high from N+1 until ARVALID&ARREADY, then go to RD_DATA.
- RD_DATA: RREADY=1; on RVALID&RREADY, capture RDATA and RRESP, go to RSP.
- RSP:
  - rsp_valid=1, outputs stable until rsp_valid&rsp_ready, then go to IDLE.
  - cmd_ready stays 0 until the IDLE state is entered. There is no same-cycle re-accept.
- VALID outputs never depend combinationally on READY inputs. Address/data outputs are stable while their VALID is high.
- AWPROT=ARPROT=3'b000 constant.
- Minimum latency with an always-ready slave that answers in 1 cycle:
  - Command accepted at N, AW/W handshake at N+1, BVALID at N+2, rsp_valid at N+3.
  - Reads follow the same timing.
- Watchdog:
  - 16-bit counter clears on every state change and increments in WR/WR_RESP/RD/RD_DATA.
  - When it reaches TIMEOUT_CYCLES, timeout is set and the counter saturates.
  - The FSM keeps waiting; AXI transactions are never aborted.
  - timeout is sticky and clears on the next command accept.
- Slave errors (SLVERR=2'b10, DECERR=2'b11) are passed through unchanged and do not set timeout.

Decomposition:
- axi_lite_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - master state_t enum.
  - DATA_WIDTH=32 constant.
  - Shared later by the regfile slave.
- No sub-module; the watchdog counter is inline.

Test Plan:
- Write 0xA5A50001 to 0x08 with AWREADY before WREADY (2 cycles apart) -> one AW and one W handshake each, rsp_resp=OKAY, rsp_write=1, regfile reg2 reads back 0xA5A50001.
- Read 0x00 then 0x04 -> rsp_rdata=0xDEADBEEF, then 0x76543210, rsp_resp=OKAY, cmd_ready low between accept and rsp handshake.
- Back-pressure: rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable; cmd_valid held high is not accepted until 1 cycle after rsp handshake.
- Slave holds ARREADY low for TIMEOUT_CYCLES=16 -> timeout=1 at cycle 16 of waiting, ARVALID still high; ARREADY then rises -> read completes, timeout cleared on next accept.
- Slave returns BRESP=SLVERR for address 0x40 -> rsp_resp=2'b10, timeout=0.
- Assert axi_areset while AWVALID=1 -> AWVALID, WVALID, BREADY, rsp_valid all 0 in the same cycle; after release, state IDLE and cmd_ready=1.
